// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
//   Shared types and address map for the APB completer register bank.
//   apb_fsm_e     : transfer FSM states (IDLE -> ACCESS -> DONE -> IDLE)
//   ADDR_ID       : byte offset of the read-only ID register
//   ADDR_WAITCFG  : byte offset of the wait-state configuration register
//   ADDR_SCRATCH0 : byte offset of the first byte-strobed scratch register
//   WAITCFG_W     : width of the wait-state count held in WAITCFG
// ---------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } apb_fsm_e;

    localparam int ADDR_ID       = 0;
    localparam int ADDR_WAITCFG  = 4;
    localparam int ADDR_SCRATCH0 = 8;

    localparam int WAITCFG_W     = 4;

endpackage : apb_pkg

// File: rtl/apb_regbank.sv
// ---------------------------------------------------------------------------
// apb_regbank
//   Storage for the completer: read-only ID, WAITCFG and DEPTH-2 scratch
//   words. Provides a combinational address decoder (used at the APB setup
//   cycle), a byte-strobed write port and a read mux addressed by the word
//   index latched by the transfer FSM.
//
//   clk_i        in   clock
//   rst_i        in   asynchronous, active-high reset
//   dec_addr_i   in   byte address to classify (raw paddr)
//   dec_write_i  in   direction of the access being classified
//   dec_err_o    out  1 = misaligned, out of range, or write to ID
//   idx_i        in   word index for read mux and write port
//   we_i         in   commit a write to idx_i on this clock edge
//   wdata_i      in   write data
//   wstrb_i      in   write byte strobes
//   rdata_o      out  contents of register idx_i (0 if idx_i >= DEPTH)
//   waitcfg_o    out  current wait-state count
// ---------------------------------------------------------------------------
module apb_regbank
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    DEPTH        = 16,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE     = 32'hA2B0_0001,
    parameter logic [WAITCFG_W-1:0]  WAIT_DEFAULT = 4'd0,
    localparam int                   IDX_W        = $clog2(DEPTH),
    localparam int                   STRB_W       = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] dec_addr_i,
    input  logic                  dec_write_i,
    output logic                  dec_err_o,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [STRB_W-1:0]     wstrb_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [WAITCFG_W-1:0]  waitcfg_o
);

    localparam logic [IDX_W-1:0] IDX_ID      = IDX_W'(ADDR_ID >> 2);
    localparam logic [IDX_W-1:0] IDX_WAITCFG = IDX_W'(ADDR_WAITCFG >> 2);
    localparam int               FIRST_SCR   = ADDR_SCRATCH0 >> 2;

    logic [WAITCFG_W-1:0]  waitcfg_q;
    logic [DATA_WIDTH-1:0] scratch_q [FIRST_SCR:DEPTH-1];

    // Full-width word address so that any high paddr bit lands out of range.
    logic [ADDR_WIDTH-1:0] word_addr;
    assign word_addr = dec_addr_i >> 2;

    always_comb begin
        dec_err_o = 1'b0;
        if (dec_addr_i[1:0] != 2'b00) begin
            dec_err_o = 1'b1;
        end else if (word_addr >= ADDR_WIDTH'(DEPTH)) begin
            dec_err_o = 1'b1;
        end else if (dec_write_i && (word_addr == ADDR_WIDTH'(ADDR_ID >> 2))) begin
            dec_err_o = 1'b1;
        end
    end

    // Read mux. Indices that are not backed by storage read as zero.
    always_comb begin
        rdata_o = '0;
        if (idx_i == IDX_ID) begin
            rdata_o = ID_VALUE;
        end else if (idx_i == IDX_WAITCFG) begin
            rdata_o = {{(DATA_WIDTH-WAITCFG_W){1'b0}}, waitcfg_q};
        end else if ((int'(idx_i) >= FIRST_SCR) && (int'(idx_i) < DEPTH)) begin
            rdata_o = scratch_q[int'(idx_i)];
        end
    end

    assign waitcfg_o = waitcfg_q;

    // Write port. WAITCFG lives entirely in byte lane 0, so only pstrb[0]
    // gates it; scratch words honour every lane.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            waitcfg_q <= WAIT_DEFAULT;
            for (int w = FIRST_SCR; w < DEPTH; w++) begin
                scratch_q[w] <= '0;
            end
        end else if (we_i) begin
            if ((idx_i == IDX_WAITCFG) && wstrb_i[0]) begin
                waitcfg_q <= wdata_i[WAITCFG_W-1:0];
            end
            for (int w = FIRST_SCR; w < DEPTH; w++) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if ((idx_i == IDX_W'(w)) && wstrb_i[b]) begin
                        scratch_q[w][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule : apb_regbank

// File: rtl/apb_slave_regbank.sv
// ---------------------------------------------------------------------------
// apb_slave_regbank
//   APB3/APB4 completer with a small register bank and a programmable number
//   of wait states. A setup cycle latches the transfer; ACCESS burns WAITCFG
//   cycles; DONE drives registered pready/pslverr/prdata for one cycle and
//   commits any write on the edge that ends it.
//
//   pclk_i     in   APB clock
//   preset_i   in   asynchronous, active-high reset
//   paddr_i    in   byte address
//   psel_i     in   completer select
//   penable_i  in   access-phase indicator
//   pwrite_i   in   1 = write, 0 = read
//   pwdata_i   in   write data
//   pstrb_i    in   write byte strobes
//   prdata_o   out  read data; 0 unless a completing, error-free read
//   pready_o   out  transfer complete (one cycle, in DONE)
//   pslverr_o  out  error; only ever high together with pready_o
// ---------------------------------------------------------------------------
module apb_slave_regbank
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    DEPTH        = 16,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE     = 32'hA2B0_0001,
    parameter logic [WAITCFG_W-1:0]  WAIT_DEFAULT = 4'd0
) (
    input  logic                    pclk_i,
    input  logic                    preset_i,
    input  logic [ADDR_WIDTH-1:0]   paddr_i,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic                    pwrite_i,
    input  logic [DATA_WIDTH-1:0]   pwdata_i,
    input  logic [DATA_WIDTH/8-1:0] pstrb_i,
    output logic [DATA_WIDTH-1:0]   prdata_o,
    output logic                    pready_o,
    output logic                    pslverr_o
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int STRB_W = DATA_WIDTH / 8;

    apb_fsm_e              state_q,   state_d;
    logic [WAITCFG_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]      idx_q,     idx_d;
    logic                  write_q,   write_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [STRB_W-1:0]     strb_q,    strb_d;
    logic                  errflag_q, errflag_d;
    logic                  pready_q,  pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q,  prdata_d;

    logic                  dec_err;
    logic                  commit;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [WAITCFG_W-1:0]  waitcfg;

    apb_regbank #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .DEPTH        (DEPTH),
        .ID_VALUE     (ID_VALUE),
        .WAIT_DEFAULT (WAIT_DEFAULT)
    ) u_regbank (
        .clk_i       (pclk_i),
        .rst_i       (preset_i),
        .dec_addr_i  (paddr_i),
        .dec_write_i (pwrite_i),
        .dec_err_o   (dec_err),
        .idx_i       (idx_q),
        .we_i        (commit),
        .wdata_i     (wdata_q),
        .wstrb_i     (strb_q),
        .rdata_o     (rd_data),
        .waitcfg_o   (waitcfg)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        idx_d      = idx_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        errflag_d  = errflag_q;
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;
        prdata_d   = '0;
        commit     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Only a genuine setup cycle starts a transfer; a stray
                // penable without a setup is ignored.
                if (psel_i && !penable_i) begin
                    state_d    = ACCESS;
                    idx_d      = paddr_i[IDX_W+1:2];
                    write_d    = pwrite_i;
                    wdata_d    = pwdata_i;
                    strb_d     = pstrb_i;
                    errflag_d  = dec_err;
                    wait_cnt_d = waitcfg;
                end
            end
            ACCESS: begin
                if (!psel_i) begin
                    state_d = IDLE;
                end else if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end else begin
                    // Outputs are registered, so they are computed on the
                    // edge that enters DONE.
                    state_d   = DONE;
                    pready_d  = 1'b1;
                    pslverr_d = errflag_q;
                    if (!write_q && !errflag_q) begin
                        prdata_d = rd_data;
                    end
                end
            end
            DONE: begin
                // The write lands on the edge that ends DONE; a setup seen
                // here is not taken and the master re-presents it.
                state_d = IDLE;
                commit  = write_q && !errflag_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            idx_q      <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            strb_q     <= '0;
            errflag_q  <= 1'b0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            idx_q      <= idx_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            errflag_q  <= errflag_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            prdata_q   <= prdata_d;
        end
    end

    assign pready_o  = pready_q;
    assign pslverr_o = pslverr_q;
    assign prdata_o  = prdata_q;

endmodule : apb_slave_regbank

// File: tb/tb_apb_slave_regbank.sv
// ---------------------------------------------------------------------------
// tb_apb_slave_regbank
//   Directed bench for apb_slave_regbank: reset values, ID read, strobed
//   scratch writes, wait-state latency, decode errors, master abort,
//   mid-transfer reset, then a short back-to-back sequence checked against a
//   register model.
//   Handshake: a transfer is a setup cycle (psel=1, penable=0) followed by
//   access cycles (psel=1, penable=1) until pready=1; inputs are held until
//   the edge that samples pready=1.
// ---------------------------------------------------------------------------
module tb_apb_slave_regbank;

    localparam logic [31:0] ID_VAL = 32'hA2B0_0001;
    localparam int          MAX_LAT = 40;

    logic        pclk;
    logic        preset;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [31:0] model [16];
    logic [31:0] exp_q [$];

    apb_slave_regbank dut (
        .pclk_i    (pclk),
        .preset_i  (preset),
        .paddr_i   (paddr),
        .psel_i    (psel),
        .penable_i (penable),
        .pwrite_i  (pwrite),
        .pwdata_i  (pwdata),
        .pstrb_i   (pstrb),
        .prdata_o  (prdata),
        .pready_o  (pready),
        .pslverr_o (pslverr)
    );

    // clock / reset
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drives one complete APB transfer starting #1 after a rising edge.
    // lat counts rising edges from the setup edge up to the one that
    // produces pready.
    task automatic apb_xfer(input string tag, input logic [31:0] a, input logic w,
                            input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] rd, output logic err, output int lat);
        bit done;
        done    = 1'b0;
        rd      = '0;
        err     = 1'b0;
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = a;
        pwrite  = w;
        pwdata  = d;
        pstrb   = s;
        @(posedge pclk); #1;
        penable = 1'b1;
        lat     = 1;
        while (!done && lat < MAX_LAT) begin
            @(negedge pclk);
            if (pready === 1'b1) begin
                rd   = prdata;
                err  = pslverr;
                done = 1'b1;
            end else begin
                @(posedge pclk); #1;
                lat++;
            end
        end
        if (!done) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end
        @(posedge pclk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        // pready must be a single-cycle pulse
        @(negedge pclk);
        check({tag, "_pready_pulse"}, {31'd0, pready}, 32'd0);
        @(posedge pclk); #1;
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic exp_err);
        logic [31:0] rd;
        logic        err;
        int          lat;
        apb_xfer(tag, a, 1'b1, d, s, rd, err, lat);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                           input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        err;
        int          lat;
        apb_xfer(tag, a, 1'b0, 32'd0, 4'd0, rd, err, lat);
        check({tag, "_data"}, rd, exp_d);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        if (exp_lat > 0) begin
            check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        end
    endtask

    initial begin
        int          seen_ready;
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          idx;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp_d;
        int          exp_lat;

        preset  = 1'b1;
        paddr   = '0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        pwdata  = '0;
        pstrb   = '0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        preset = 1'b0;
        @(posedge pclk); #1;

        // reset state
        check("rst_pready",  {31'd0, pready},  32'd0);
        check("rst_pslverr", {31'd0, pslverr}, 32'd0);
        check("rst_prdata",  prdata,           32'd0);

        // 1. ID read, minimum latency
        do_read("t1_id", 32'h00, ID_VAL, 1'b0, 2);

        // 2. strobed scratch write
        do_write("t2_wr", 32'h08, 32'hDEAD_BEEF, 4'b0101, 1'b0);
        do_read("t2_rd", 32'h08, 32'h00AD_00EF, 1'b0, 2);

        // 3. wait states from the next transfer
        do_write("t3_wcfg", 32'h04, 32'h0000_0003, 4'hF, 1'b0);
        do_read("t3_rd0c", 32'h0C, 32'h0, 1'b0, 5);
        do_read("t3_rdcfg", 32'h04, 32'h3, 1'b0, 5);

        // 4. decode errors
        do_write("t4_wr_id", 32'h00, 32'h1234_5678, 4'hF, 1'b1);
        do_read("t4_misal", 32'h02, 32'h0, 1'b1, 5);
        do_read("t4_range", 32'h40, 32'h0, 1'b1, 5);
        do_read("t4_id", 32'h00, ID_VAL, 1'b0, 5);

        // 5a. master abort during ACCESS with WAITCFG = 2
        do_write("t5_wcfg", 32'h04, 32'h0000_0002, 4'hF, 1'b0);
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = 32'h10;
        pwrite  = 1'b1;
        pwdata  = 32'hFFFF_FFFF;
        pstrb   = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        seen_ready = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            if (pready !== 1'b0) seen_ready++;
        end
        check("t5_abort_noready", 32'(seen_ready), 32'd0);
        @(posedge pclk); #1;
        do_read("t5_rd10", 32'h10, 32'h0, 1'b0, 4);

        // 5b. reset during ACCESS
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = 32'h08;
        pwrite  = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b1;
        #1;
        check("t5_rst_pready",  {31'd0, pready},  32'd0);
        check("t5_rst_pslverr", {31'd0, pslverr}, 32'd0);
        check("t5_rst_prdata",  prdata,           32'd0);
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge pclk);
        preset = 1'b0;
        @(posedge pclk); #1;
        do_read("t5_rst_wcfg", 32'h04, 32'h0, 1'b0, 2);
        do_read("t5_rst_scr", 32'h08, 32'h0, 1'b0, 2);

        // 6. back-to-back transfers against a register model
        model[0] = ID_VAL;
        for (int i = 1; i < 16; i++) model[i] = '0;
        for (int n = 0; n < 16; n++) begin
            exp_lat = int'(model[1][3:0]) + 2;
            if ($urandom_range(0, 1) == 1) begin
                idx = $urandom_range(1, 15);
                d   = (idx == 1) ? 32'($urandom_range(0, 3)) : $urandom;
                s   = 4'($urandom_range(0, 15));
                apb_xfer("t6_wr", 32'(idx * 4), 1'b1, d, s, rd, err, lat);
                check("t6_wr_err", {31'd0, err}, 32'd0);
                if (idx == 1) begin
                    if (s[0]) model[1] = {28'd0, d[3:0]};
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
                    end
                end
            end else begin
                idx = $urandom_range(0, 15);
                exp_q.push_back(model[idx]);
                apb_xfer("t6_rd", 32'(idx * 4), 1'b0, 32'd0, 4'd0, rd, err, lat);
                exp_d = exp_q.pop_front();
                check("t6_rd_data", rd, exp_d);
                check("t6_rd_err", {31'd0, err}, 32'd0);
            end
            check("t6_lat", 32'(lat), 32'(exp_lat));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_apb_slave_regbank
